// File: rtl/mem_sequencer.sv
// Multicycle sequencer that shares one memory port between instruction fetch
// and data access. The MEM_TIMEOUT_EN macro adds a request watchdog and a HALT state.
module mem_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] dmem_wd,
  input  logic        is_load,
  input  logic        is_store,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instruction,
  output logic [31:0] dmem_rd,
  output logic        commit,
  output logic        busy,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    COMMIT = 3'd4
`ifdef MEM_TIMEOUT_EN
    , HALT = 3'd5
`endif
  } state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_sequencer: TIMEOUT must be in 2..255");
  end

  state_t      state;
  logic [31:0] addr_q;

  // The PC register loads on the same edge that enters FETCH, so the fetch
  // address is taken straight from pc, which is stable for the whole FETCH.
  assign mem_addr = (state == FETCH) ? pc : addr_q;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_q;
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      addr_q      <= '0;
      mem_wdata   <= '0;
      instruction <= '0;
      dmem_rd     <= '0;
      commit      <= 1'b0;
      busy        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      commit <= 1'b0;
      case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
          busy    <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        FETCH: if (mem_ack) begin
          instruction <= mem_rdata;
          mem_req     <= 1'b0;
          state       <= EXEC;
        end
        EXEC: begin
          if (is_store || is_load) begin
            // store wins when both decode bits are set
            state     <= MEM;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            addr_q    <= alu_out;
            mem_wdata <= dmem_wd;
`ifdef MEM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end else begin
            state  <= COMMIT;
            commit <= 1'b1;
          end
        end
        MEM: if (mem_ack) begin
          if (!mem_we) dmem_rd <= mem_rdata;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= COMMIT;
          commit  <= 1'b1;
        end
        COMMIT: begin
          state   <= FETCH;
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        default: ;
      endcase
`ifdef MEM_TIMEOUT_EN
      // Watchdog overrides the case above when a request goes unanswered too long.
      if ((state == FETCH || state == MEM) && !mem_ack) begin
        if (wait_cnt == 8'(TIMEOUT - 1)) begin
          err_q   <= 1'b1;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= HALT;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: lockstep memory/datapath model that
// tracks PC, latched instruction and load data from the instruction stream.
module tb_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc, alu_out, dmem_wd, mem_rdata;
  logic        is_load, is_store, mem_ack;
  logic        mem_req, mem_we, commit, busy, mem_err;
  logic [31:0] mem_addr, mem_wdata, instruction, dmem_rd;

  int total = 0;
  int bad = 0;
  logic [31:0] pc_m, instr_m, rd_m;

  mem_sequencer #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .pc(pc), .alu_out(alu_out), .dmem_wd(dmem_wd),
    .is_load(is_load), .is_store(is_store), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .instruction(instruction), .dmem_rd(dmem_rd),
    .commit(commit), .busy(busy), .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  // kind: 0 = ALU op, 1 = load, 2 = store, 3 = load+store decode
  // fw/mw: ack wait cycles in fetch/data phase; abort: reset in first MEM cycle
  task automatic drive_instr(input int kind, input int fw, input int mw,
                             input logic [31:0] iw, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [31:0] rdat,
                             input bit chg, input bit abort);
    logic        exp_we;
    logic [31:0] wd_cap;
    for (int i = 0; i <= fw; i++) begin
      @(negedge clock);
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== pc_m || commit !== 1'b0 ||
          busy !== 1'b1 || instruction !== instr_m || mem_err !== 1'b0) begin
        bad++;
        $display("FAIL fetch: req=%b we=%b addr=%h commit=%b busy=%b instr=%h err=%b, want req=1 we=0 addr=%h commit=0 busy=1 instr=%h err=0",
                 mem_req, mem_we, mem_addr, commit, busy, instruction, mem_err, pc_m, instr_m);
      end
      mem_ack   = (i == fw);
      mem_rdata = (i == fw) ? iw : $urandom;
    end
    instr_m = iw;
    @(negedge clock);
    total++;
    if (mem_req !== 1'b0 || commit !== 1'b0 || busy !== 1'b1 || instruction !== iw) begin
      bad++;
      $display("FAIL exec: req=%b commit=%b busy=%b instr=%h, want req=0 commit=0 busy=1 instr=%h",
               mem_req, commit, busy, instruction, iw);
    end
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    is_load   = (kind == 1 || kind == 3);
    is_store  = (kind >= 2);
    alu_out   = alu;
    dmem_wd   = wd;
    if (kind != 0) begin
      exp_we = (kind >= 2);
      wd_cap = wd;
      for (int j = 0; j <= mw; j++) begin
        @(negedge clock);
        total++;
        if (mem_req !== 1'b1 || mem_we !== exp_we || mem_addr !== alu || commit !== 1'b0 ||
            (exp_we && mem_wdata !== wd_cap)) begin
          bad++;
          $display("FAIL mem: req=%b we=%b addr=%h wdata=%h commit=%b, want req=1 we=%b addr=%h wdata=%h commit=0",
                   mem_req, mem_we, mem_addr, mem_wdata, commit, exp_we, alu, wd_cap);
        end
        if (chg) begin
          dmem_wd = $urandom;
          alu_out = $urandom;
        end
        if (abort) begin
          reset   = 1'b1;
          mem_ack = 1'b0;
          @(negedge clock);
          total++;
          if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
              instruction !== 32'h0 || dmem_rd !== 32'h0 || commit !== 1'b0 || busy !== 1'b0 ||
              mem_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: req=%b we=%b addr=%h wdata=%h instr=%h rd=%h commit=%b busy=%b err=%b, want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, instruction, dmem_rd, commit, busy, mem_err);
          end
          // stray late ack while no request is outstanding
          reset     = 1'b0;
          mem_ack   = 1'b1;
          mem_rdata = 32'hBAD0BAD0;
          is_load   = 1'b0;
          is_store  = 1'b0;
          instr_m   = 32'h0;
          rd_m      = 32'h0;
          return;
        end
        mem_ack   = (j == mw);
        mem_rdata = (j == mw) ? rdat : $urandom;
      end
      if (!exp_we) rd_m = rdat;
    end
    @(negedge clock);
    total++;
    if (commit !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b1 || dmem_rd !== rd_m || instruction !== iw) begin
      bad++;
      $display("FAIL commit: commit=%b req=%b busy=%b rd=%h instr=%h, want commit=1 req=0 busy=1 rd=%h instr=%h",
               commit, mem_req, busy, dmem_rd, instruction, rd_m, iw);
    end
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    is_load   = 1'b0;
    is_store  = 1'b0;
    pc_m      = pc_m + 32'd4;
    pc        = pc_m;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; pc = '0; alu_out = '0;
    dmem_wd = '0; is_load = 1'b0; is_store = 1'b0;
    pc_m = '0; instr_m = '0; rd_m = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
          instruction !== 32'h0 || dmem_rd !== 32'h0 || commit !== 1'b0 || busy !== 1'b0 ||
          mem_err !== 1'b0) begin
        bad++;
        $display("FAIL reset: req=%b we=%b addr=%h wdata=%h instr=%h rd=%h commit=%b busy=%b err=%b, want all 0",
                 mem_req, mem_we, mem_addr, mem_wdata, instruction, dmem_rd, commit, busy, mem_err);
      end
      mem_ack = 1'b1;
    end
    mem_ack = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic test_alu();
    drive_instr(0, 0, 0, 32'h2008_0005, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_load();
    drive_instr(1, 0, 2, 32'h8C08_0040, 32'h40, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
  endtask

  task automatic test_store();
    drive_instr(2, 1, 2, 32'hAC08_0080, 32'h80, 32'h12345678, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_both();
    drive_instr(3, 0, 1, 32'hFC00_0010, 32'h10, 32'hCAFEF00D, 32'h5555AAAA, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive_instr(1, 1, 3, 32'h8C09_0100, 32'h100, 32'h0, 32'h0, 1'b0, 1'b1);
    drive_instr(0, 0, 0, 32'h2009_0001, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++)
      drive_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                  $urandom, 1'($urandom_range(0, 1)), 1'b0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (mem_req !== 1'b1 || mem_err !== 1'b0 || mem_addr !== pc_m) begin
        bad++;
        $display("FAIL timeout_wait: req=%b err=%b addr=%h, want req=1 err=0 addr=%h",
                 mem_req, mem_err, mem_addr, pc_m);
      end
      mem_ack = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++;
      if (mem_err !== 1'b1 || mem_req !== 1'b0 || busy !== 1'b0 || commit !== 1'b0) begin
        bad++;
        $display("FAIL timeout_halt: err=%b req=%b busy=%b commit=%b, want err=1 req=0 busy=0 commit=0",
                 mem_err, mem_req, busy, commit);
      end
      mem_ack = 1'($urandom_range(0, 1));
    end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (mem_err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: err=%b busy=%b, want err=0 busy=0", mem_err, busy);
    end
    reset = 1'b0; mem_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_both();
    test_reset_mid();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multicycle sequencer that lets the MIPS datapath run from a single shared memory port instead of separate instruction and data memories. It owns the memory handshake, fetches each instruction and latches it, and optionally performs one data access per instruction. It emits a single-cycle `commit` pulse that gates the PC register and the register-file write enable, so the datapath advances exactly once per instruction.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles `mem_req` may stay high without `mem_ack`. Used only when `MEM_TIMEOUT_EN` is defined. Legal range 2..255.

Ports:
- `clock` in 1: single clock for the block; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `pc` in 32: current PC from the datapath.
- `alu_out` in 32: data address from the datapath ALU.
- `dmem_wd` in 32: store data from the datapath (register-file read port 1).
- `is_load` in 1: control decode of the latched instruction (`lw`).
- `is_store` in 1: control decode of the latched instruction (`sw`).
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable (1 = write).
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid in the cycle `mem_ack` is high.
- `mem_ack` in 1: memory completion.
- `instruction` out 32: latched instruction fed to the datapath and control.
- `dmem_rd` out 32: latched load data fed to the datapath result mux.
- `commit` out 1: one-cycle pulse. It is ANDed into the PC register load and into `rf_we`.
- `busy` out 1: high in every state except `IDLE` and `HALT`.
- `mem_err` out 1: sticky timeout flag.

## Operation
- States: `IDLE`, `FETCH`, `EXEC`, `MEM`, `COMMIT`, `HALT`. `HALT` exists only when `MEM_TIMEOUT_EN` is defined.
- `IDLE`: entered on reset. Moves to `FETCH` on the first cycle `reset` is low.
- `FETCH`:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=`pc`.
  - When `mem_ack` is sampled, latches `mem_rdata` into `instruction` and moves to `EXEC`.
- `EXEC`: one settle cycle for decode and ALU; no request is issued.
  - If `is_store`: move to `MEM` as a write.
  - Else if `is_load`: move to `MEM` as a read.
  - Otherwise: move to `COMMIT`.
  - If both `is_load` and `is_store` are high, the store wins and `dmem_rd` is unchanged.
- `MEM`:
  - Drives `mem_req`=1, `mem_addr`=`alu_out`, and `mem_we`/`mem_wdata`=`dmem_wd` captured at the `EXEC`→`MEM` edge.
  - Address and data are registered and stay stable throughout `MEM`.
  - On `mem_ack`: a read latches `mem_rdata` into `dmem_rd`; then move to `COMMIT`.
- `COMMIT`: `commit`=1 for exactly this cycle; then move to `FETCH`.
- Handshake rules:
  - While `mem_req` is high, `mem_addr`, `mem_we` and `mem_wdata` do not change until the `mem_ack` cycle.
  - Same-cycle ack (zero wait) is legal.
  - `mem_req` is low in the cycle after ack.
  - `mem_ack` while `mem_req`=0 is ignored.
- Addresses pass through unmodified (no alignment check). The PC is word aligned by construction.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `instruction`=0, `dmem_rd`=0, `commit`=0, `busy`=0, `mem_err`=0, state=`IDLE`.
- Zero-wait memory:
  - Non-memory instruction: 3 cycles per instruction (`FETCH`, `EXEC`, `COMMIT`).
  - Load/store: 4 cycles.
- Each wait cycle of `mem_ack` adds one cycle in `FETCH` or `MEM`.
- `commit` never asserts twice without an intervening `FETCH`.
- The PC changes only on the edge that ends `COMMIT`.
- Reset mid-operation (any state, including a request outstanding):
  - On the reset edge, all outputs take their reset values and the state becomes `IDLE`.
  - A late `mem_ack` after reset is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to `FETCH` or `MEM` and increments every cycle that `mem_req`=1 and `mem_ack`=0.
  - When the count reaches `TIMEOUT` with no ack, on that edge: set `mem_err`=1, drop `mem_req`, move to `HALT`.
  - `HALT` holds with `busy`=0 and `commit`=0 until reset.
- `MEM_TIMEOUT_EN` undefined:
  - No counter and no `HALT` state; the block waits indefinitely for `mem_ack`.
  - `mem_err` is tied to 0.

## Test plan
- Zero-wait memory, `pc`=0x0, `addi` fetched (`is_load`=`is_store`=0) -> `mem_req` high one cycle with `mem_addr`=0x0; `commit` pulses on cycle 3 after reset release; no second request before `commit`.
- `lw` with `alu_out`=0x40, memory returns 0xDEADBEEF after 2 wait cycles -> `mem_we`=0 and `mem_addr`=0x40 stable for 3 cycles; `dmem_rd`=0xDEADBEEF; `commit` follows 1 cycle after ack.
- `sw` with `alu_out`=0x80, `dmem_wd`=0x12345678, then `dmem_wd` changed during the wait -> `mem_we`=1 and `mem_wdata` stays 0x12345678 until ack.
- Both `is_load` and `is_store` high -> write issued; `dmem_rd` keeps its previous value.
- `reset` asserted in `MEM` with a request outstanding, ack arrives a cycle later -> all outputs 0 on the reset edge; stray ack ignored; next fetch at the current `pc` after release.
- `MEM_TIMEOUT_EN`, `TIMEOUT`=4, `mem_ack` held 0 in `FETCH` -> `mem_err`=1 and `mem_req`=0 after 4 request cycles; `busy`=0; no `commit` until reset.
